uart_tx_scheduler: RTL and testbench

//  Round-robin scheduler that shares one UART transmitter between NUM_REQ byte sources (APB write path, loopback, etc.).

---
 rtl/uart_tx_scheduler.sv | 155 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte sources.
// It captures the winning byte and parity mode, launches the frame, and follows tx_busy until the frame ends.
module uart_tx_scheduler #(
    parameter  int DATA_WIDTH   = 8,
    parameter  int NUM_REQ      = 2,
    parameter  int GAP_CYCLES   = 1,
    parameter  int BUSY_TIMEOUT = 4,
    localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          UCLK,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_parity_en,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          done,
    output logic                          err_timeout,
    output logic [ID_W-1:0]               active_id,
    output logic                          sched_busy,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_parity_enable,
    output logic                          tx_data_valid,
    input  logic                          tx_busy,
    output logic [2:0]                    fsm_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [ID_W:0]    NREQ_W   = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    state_t              state, state_nxt;
    logic [ID_W-1:0]     ptr, ptr_nxt;
    logic [TO_W-1:0]     to_cnt, to_nxt;
    logic [GAP_W-1:0]    gap_cnt, gap_nxt;
    logic [NUM_REQ-1:0]  ack_nxt;
    logic                done_nxt, err_nxt, capture;
    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [ID_W:0]       idx;

    // First asserted request at or after the pointer, wrapping past the last source.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (ID_W + 1)'(k);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (!win_found && req[idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        to_nxt    = to_cnt;
        gap_nxt   = gap_cnt;
        ack_nxt   = '0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                // A frame already on the line (tx_busy high) blocks any new grant.
                if (win_found && !tx_busy) begin
                    capture         = 1'b1;
                    ack_nxt[win_id] = 1'b1;
                    ptr_nxt         = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
                    state_nxt       = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                to_nxt    = '0;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    to_nxt = to_cnt + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    done_nxt = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        gap_nxt   = GAP_LOAD;
                        state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt <= GAP_ONE) state_nxt = S_IDLE;
                else                    gap_nxt   = gap_cnt - 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge UCLK or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            ptr              <= '0;
            to_cnt           <= '0;
            gap_cnt          <= '0;
            ack              <= '0;
            done             <= 1'b0;
            err_timeout      <= 1'b0;
            tx_data          <= '0;
            tx_parity_enable <= 1'b0;
            active_id        <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            to_cnt      <= to_nxt;
            gap_cnt     <= gap_nxt;
            ack         <= ack_nxt;
            done        <= done_nxt;
            err_timeout <= err_nxt;
            if (capture) begin
                tx_data          <= req_data[win_id*DATA_WIDTH +: DATA_WIDTH];
                tx_parity_enable <= req_parity_en[win_id];
                active_id        <= win_id;
            end
        end
    end

    // Handshake: tx_data_valid is a request that stays up from LAUNCH until tx_busy is seen high;
    // tx_busy acts as the acceptance, so valid drops combinationally once the Tx reports busy.
    assign tx_data_valid = (state == S_LAUNCH) || ((state == S_WAIT_BUSY) && !tx_busy);
    assign sched_busy    = (state != S_IDLE);
    assign fsm_state     = state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: one instance with a one-cycle gap and one with no gap,
// each driven by a Tx model that raises tx_busy one cycle after tx_data_valid and holds it 11 cycles.
`timescale 1ns/1ps

module tb_uart_tx_scheduler;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance with GAP_CYCLES = 1
  logic [1:0]  req, req_par, ack;
  logic [15:0] req_data;
  logic        done, err_timeout, active_id, sched_busy;
  logic [7:0]  tx_data;
  logic        tx_parity_enable, tx_data_valid, tx_busy;
  logic [2:0]  fsm_state;

  // instance with GAP_CYCLES = 0
  logic [1:0]  req_z, req_par_z, ack_z;
  logic [15:0] req_data_z;
  logic        done_z, err_timeout_z, active_id_z, sched_busy_z;
  logic [7:0]  tx_data_z;
  logic        tx_parity_enable_z, tx_data_valid_z, tx_busy_z;
  logic [2:0]  fsm_state_z;

  uart_tx_scheduler #(.DATA_WIDTH(8), .NUM_REQ(2), .GAP_CYCLES(1), .BUSY_TIMEOUT(4)) dut (
    .UCLK(clk), .reset(rst_n), .req(req), .req_data(req_data), .req_parity_en(req_par),
    .ack(ack), .done(done), .err_timeout(err_timeout), .active_id(active_id),
    .sched_busy(sched_busy), .tx_data(tx_data), .tx_parity_enable(tx_parity_enable),
    .tx_data_valid(tx_data_valid), .tx_busy(tx_busy), .fsm_state(fsm_state)
  );

  uart_tx_scheduler #(.DATA_WIDTH(8), .NUM_REQ(2), .GAP_CYCLES(0), .BUSY_TIMEOUT(4)) dut_z (
    .UCLK(clk), .reset(rst_n), .req(req_z), .req_data(req_data_z), .req_parity_en(req_par_z),
    .ack(ack_z), .done(done_z), .err_timeout(err_timeout_z), .active_id(active_id_z),
    .sched_busy(sched_busy_z), .tx_data(tx_data_z), .tx_parity_enable(tx_parity_enable_z),
    .tx_data_valid(tx_data_valid_z), .tx_busy(tx_busy_z), .fsm_state(fsm_state_z)
  );

  // Tx models
  logic [3:0] m_cnt, m_cnt_z;
  logic       model_en, ext_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         m_cnt <= 4'd0;
    else if (m_cnt != 4'd0)             m_cnt <= m_cnt - 4'd1;
    else if (tx_data_valid && model_en) m_cnt <= 4'd11;
  end
  assign tx_busy = (m_cnt != 4'd0) || ext_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               m_cnt_z <= 4'd0;
    else if (m_cnt_z != 4'd0) m_cnt_z <= m_cnt_z - 4'd1;
    else if (tx_data_valid_z) m_cnt_z <= 4'd11;
  end
  assign tx_busy_z = (m_cnt_z != 4'd0);

  task automatic fail(input string tag, input longint obs, input longint exp);
    n_fail++;
    $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // scoreboard: the byte of every frame on the line, in grant order
  logic [7:0] exp_q[$];
  logic [7:0] exp_data;
  logic       exp_par;

  always @(negedge clk) begin
    if (rst_n && m_cnt != 4'd0) begin
      n_checks++;
      if (tx_data !== exp_data) fail("frame_data", tx_data, exp_data);
      n_checks++;
      if (tx_parity_enable !== exp_par) fail("frame_par", tx_parity_enable, exp_par);
    end
    if (rst_n && m_cnt_z != 4'd0) begin
      n_checks++;
      if (tx_data_z !== 8'h96) fail("frame_data_z", tx_data_z, 8'h96);
      n_checks++;
      if (tx_parity_enable_z !== 1'b1) fail("frame_par_z", tx_parity_enable_z, 1);
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // driver helpers
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int         cyc;
  int         nv;
  logic [1:0] exp_ack;

  initial begin
    rst_n = 1'b0; model_en = 1'b1; ext_busy = 1'b0;
    req = '0; req_data = '0; req_par = '0;
    req_z = '0; req_data_z = '0; req_par_z = '0;
    exp_data = '0; exp_par = 1'b0;
    step(2);

    // reset values
    n_checks++; if (ack !== 2'b00) fail("rst_ack", ack, 0);
    n_checks++; if (done !== 1'b0) fail("rst_done", done, 0);
    n_checks++; if (err_timeout !== 1'b0) fail("rst_err", err_timeout, 0);
    n_checks++; if (tx_data_valid !== 1'b0) fail("rst_valid", tx_data_valid, 0);
    n_checks++; if (sched_busy !== 1'b0) fail("rst_sched_busy", sched_busy, 0);
    n_checks++; if (tx_data !== 8'h00) fail("rst_tx_data", tx_data, 0);
    n_checks++; if (tx_parity_enable !== 1'b0) fail("rst_par", tx_parity_enable, 0);
    n_checks++; if (active_id !== 1'b0) fail("rst_active_id", active_id, 0);
    n_checks++; if (fsm_state !== ST_IDLE) fail("rst_state", fsm_state, ST_IDLE);
    rst_n = 1'b1;
    step(1);

    // 1: single request from source 0
    req = 2'b01; req_data = 16'h00A5; req_par = 2'b01;
    exp_data = 8'hA5; exp_par = 1'b1;
    step(1);
    n_checks++; if (ack !== 2'b01) fail("t1_ack", ack, 1);
    n_checks++; if (tx_data !== 8'hA5) fail("t1_tx_data", tx_data, 8'hA5);
    n_checks++; if (tx_parity_enable !== 1'b1) fail("t1_par", tx_parity_enable, 1);
    n_checks++; if (tx_data_valid !== 1'b1) fail("t1_valid", tx_data_valid, 1);
    n_checks++; if (sched_busy !== 1'b1) fail("t1_sched_busy", sched_busy, 1);
    n_checks++; if (active_id !== 1'b0) fail("t1_active_id", active_id, 0);
    req = 2'b00;
    step(1);
    n_checks++; if (ack !== 2'b00) fail("t1_ack_pulse", ack, 0);
    n_checks++; if (tx_data_valid !== 1'b0) fail("t1_valid_one_cycle", tx_data_valid, 0);
    n_checks++; if (fsm_state !== ST_WAIT_BUSY) fail("t1_state_wait_busy", fsm_state, ST_WAIT_BUSY);
    cyc = 0;
    while (tx_busy && cyc < 40) begin step(1); cyc++; end
    n_checks++; if (tx_busy !== 1'b0) fail("t1_busy_fall", tx_busy, 0);
    n_checks++; if (done !== 1'b0) fail("t1_done_early", done, 0);
    step(1);
    n_checks++; if (done !== 1'b1) fail("t1_done", done, 1);
    n_checks++; if (sched_busy !== 1'b1) fail("t1_in_gap", sched_busy, 1);
    step(1);
    n_checks++; if (done !== 1'b0) fail("t1_done_pulse", done, 0);
    n_checks++; if (sched_busy !== 1'b0) fail("t1_idle", sched_busy, 0);

    // 2: both sources hold requests; grants alternate from source 0
    rst_n = 1'b0; step(1); rst_n = 1'b1; step(1);
    req = 2'b11; req_data = 16'h2211; req_par = 2'b00; exp_par = 1'b0;
    exp_q = '{8'h11, 8'h22, 8'h11, 8'h22};
    for (int g = 0; g < 4; g++) begin
      cyc = (g == 0) ? 0 : 1;
      while (ack == 2'b00 && cyc < 40) begin step(1); cyc++; end
      exp_ack  = (g % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = exp_q.pop_front();
      n_checks++; if (ack !== exp_ack) fail("t2_grant", ack, exp_ack);
      n_checks++; if (tx_data !== exp_data) fail("t2_tx_data", tx_data, exp_data);
      n_checks++; if (active_id !== exp_ack[1]) fail("t2_active_id", active_id, exp_ack[1]);
      if (g > 0) begin
        n_checks++; if (cyc != 15) fail("t2_period", cyc, 15);
      end
      if (g == 3) req = 2'b00;
      step(1);
      n_checks++; if (ack !== 2'b00) fail("t2_ack_pulse", ack, 0);
    end
    cyc = 0;
    while (sched_busy && cyc < 40) begin step(1); cyc++; end
    n_checks++; if (sched_busy !== 1'b0) fail("t2_idle", sched_busy, 0);

    // 3: Tx never reports busy -> timeout, then normal service
    model_en = 1'b0;
    req = 2'b01; req_data = 16'h003C; req_par = 2'b01;
    step(1);
    n_checks++; if (ack !== 2'b01) fail("t3_ack", ack, 1);
    req = 2'b00;
    nv = 0;
    while (tx_data_valid && nv < 20) begin nv++; step(1); end
    n_checks++; if (nv != 5) fail("t3_valid_cycles", nv, 5);
    n_checks++; if (err_timeout !== 1'b1) fail("t3_err", err_timeout, 1);
    n_checks++; if (done !== 1'b0) fail("t3_no_done", done, 0);
    n_checks++; if (sched_busy !== 1'b0) fail("t3_idle", sched_busy, 0);
    step(1);
    n_checks++; if (err_timeout !== 1'b0) fail("t3_err_pulse", err_timeout, 0);
    model_en = 1'b1;
    req = 2'b01; exp_data = 8'h3C; exp_par = 1'b1;
    step(1);
    n_checks++; if (ack !== 2'b01) fail("t3_reack", ack, 1);
    n_checks++; if (tx_data !== 8'h3C) fail("t3_re_tx_data", tx_data, 8'h3C);
    req = 2'b00;
    cyc = 0;
    while (!done && cyc < 40) begin step(1); cyc++; end
    n_checks++; if (done !== 1'b1) fail("t3_done", done, 1);
    step(2);
    n_checks++; if (sched_busy !== 1'b0) fail("t3_idle_after", sched_busy, 0);

    // 4: foreign frame in progress blocks the grant
    ext_busy = 1'b1;
    req = 2'b01; req_data = 16'h005A; req_par = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_checks++; if (ack !== 2'b00) fail("t4_no_ack", ack, 0);
      n_checks++; if (sched_busy !== 1'b0) fail("t4_stay_idle", sched_busy, 0);
    end
    ext_busy = 1'b0; exp_data = 8'h5A; exp_par = 1'b0;
    step(1);
    n_checks++; if (ack !== 2'b01) fail("t4_ack", ack, 1);
    n_checks++; if (tx_data !== 8'h5A) fail("t4_tx_data", tx_data, 8'h5A);
    req = 2'b00;
    cyc = 0;
    while (!done && cyc < 40) begin step(1); cyc++; end
    n_checks++; if (done !== 1'b1) fail("t4_done", done, 1);
    step(2);

    // 5: reset during WAIT_DONE
    req = 2'b01; req_data = 16'h0077; req_par = 2'b01; exp_data = 8'h77; exp_par = 1'b1;
    step(1);
    n_checks++; if (ack !== 2'b01) fail("t5_ack", ack, 1);
    req = 2'b00;
    step(3);
    n_checks++; if (fsm_state !== ST_WAIT_DONE) fail("t5_wait_done", fsm_state, ST_WAIT_DONE);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (sched_busy !== 1'b0) fail("t5_sched_busy", sched_busy, 0);
    n_checks++; if (tx_data_valid !== 1'b0) fail("t5_valid", tx_data_valid, 0);
    n_checks++; if (tx_data !== 8'h00) fail("t5_tx_data", tx_data, 0);
    n_checks++; if (tx_parity_enable !== 1'b0) fail("t5_par", tx_parity_enable, 0);
    n_checks++; if (active_id !== 1'b0) fail("t5_active_id", active_id, 0);
    n_checks++; if (fsm_state !== ST_IDLE) fail("t5_state", fsm_state, ST_IDLE);
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(1);
      n_checks++; if (done !== 1'b0) fail("t5_no_done", done, 0);
    end
    req = 2'b11; req_data = 16'h2211; req_par = 2'b00; exp_data = 8'h11; exp_par = 1'b0;
    step(1);
    n_checks++; if (ack !== 2'b01) fail("t5_ptr_reset", ack, 1);
    req = 2'b00;
    cyc = 0;
    while (sched_busy && cyc < 40) begin step(1); cyc++; end
    n_checks++; if (sched_busy !== 1'b0) fail("t5_idle", sched_busy, 0);

    // 6: no-gap instance, source 0 holds its request
    req_z = 2'b01; req_data_z = 16'h0096; req_par_z = 2'b01;
    step(1);
    n_checks++; if (ack_z !== 2'b01) fail("t6_ack", ack_z, 1);
    n_checks++; if (tx_data_z !== 8'h96) fail("t6_tx_data", tx_data_z, 8'h96);
    for (int f = 0; f < 2; f++) begin
      step(1);
      cyc = 0;
      while (!done_z && cyc < 40) begin step(1); cyc++; end
      n_checks++; if (done_z !== 1'b1) fail("t6_done", done_z, 1);
      n_checks++; if (ack_z !== 2'b00) fail("t6_excl", ack_z, 0);
      step(1);
      n_checks++; if (ack_z !== 2'b01) fail("t6_back_to_back_ack", ack_z, 1);
      n_checks++; if (done_z !== 1'b0) fail("t6_done_pulse", done_z, 0);
    end
    req_z = 2'b00;
    cyc = 0;
    while (sched_busy_z && cyc < 40) begin step(1); cyc++; end
    n_checks++; if (sched_busy_z !== 1'b0) fail("t6_idle", sched_busy_z, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
